// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory completer: default bus widths,
// FSM state encoding and the byte-lane merge used for strobed writes.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_WIDTH      = 32;
  localparam int APB_MAX_WIDTH  = 64;
  localparam int APB_MAX_BYTES  = APB_MAX_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_e;

  // Operates on the widest legal word; narrower callers zero-extend and truncate.
  function automatic logic [APB_MAX_WIDTH-1:0] strb_merge(
    input logic [APB_MAX_WIDTH-1:0] old,
    input logic [APB_MAX_WIDTH-1:0] wdata,
    input logic [APB_MAX_BYTES-1:0] strb
  );
    logic [APB_MAX_WIDTH-1:0] merged;
    merged = old;
    for (int i = 0; i < APB_MAX_BYTES; i++) begin
      if (strb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x WIDTH register storage: asynchronous clear, byte-lane write,
// combinational read by word index.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int WIDTH = APB_WIDTH,
  parameter int DEPTH = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [WIDTH/8-1:0] i_strb,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [WIDTH-1:0]   o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_idx == IDX_W'(i)) begin
          r_mem[i] <= WIDTH'(strb_merge(APB_MAX_WIDTH'(r_mem[i]),
                                        APB_MAX_WIDTH'(i_wdata),
                                        APB_MAX_BYTES'(i_strb)));
        end
      end
    end
  end

  // Index decode instead of direct indexing keeps non-power-of-two depths safe.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_rdata = r_mem[i];
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed register memory, with programmable
// wait states, byte strobes and an error response for addresses beyond DEPTH.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int WIDTH       = APB_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0]      pwdata,
  input  logic [WIDTH/8-1:0]    pstrb,
  output logic                  pready,
  output logic [WIDTH-1:0]      prdata,
  output logic                  pslverr
);

  localparam int         BYTES    = WIDTH / 8;
  localparam int         OFF_W    = $clog2(BYTES);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  apb_slv_state_e        r_state;
  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_in_range;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [WIDTH-1:0]      r_prdata;

  logic                  w_setup;
  logic                  w_in_range;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_full_idx;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [WIDTH-1:0]      w_mem_rdata;
  logic [WIDTH-1:0]      w_rd_word;

  assign w_setup    = psel && !penable;
  assign w_full_idx = paddr >> OFF_W;
  assign w_in_range = {1'b0, w_full_idx} < (ADDR_WIDTH+1)'(DEPTH);
  assign w_idx      = IDX_W'(w_full_idx);
  assign w_wr_en    = (r_state == READY) && psel && r_write && r_in_range;

  // A fresh setup reads at the incoming address; the last WAIT edge uses the captured one.
  assign w_rd_idx   = (r_state == WAIT) ? r_idx : w_idx;

  // Forward the write committing on this edge so a back-to-back read of the same word sees it.
  assign w_rd_word  = (w_wr_en && (w_rd_idx == r_idx))
                    ? WIDTH'(strb_merge(APB_MAX_WIDTH'(w_mem_rdata),
                                        APB_MAX_WIDTH'(pwdata),
                                        APB_MAX_BYTES'(pstrb)))
                    : w_mem_rdata;

  apb_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .i_clk    (pclk),
    .i_rst_n  (prst),
    .i_we     (w_wr_en),
    .i_wr_idx (r_idx),
    .i_wdata  (pwdata),
    .i_strb   (pstrb),
    .i_rd_idx (w_rd_idx),
    .o_rdata  (w_mem_rdata)
  );

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_in_range <= 1'b0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
    end else begin
      case (r_state)
        // READY finishes the current transfer and may accept the next setup on the same edge.
        IDLE, READY: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
          r_state   <= IDLE;
          if (w_setup) begin
            r_idx      <= w_idx;
            r_write    <= pwrite;
            r_in_range <= w_in_range;
            r_cnt      <= CNT_INIT;
            if (WAIT_CYCLES == 0) begin
              r_state   <= READY;
              r_pready  <= 1'b1;
              r_pslverr <= !w_in_range;
              r_prdata  <= (w_in_range && !pwrite) ? w_rd_word : '0;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (penable) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state   <= READY;
              r_pready  <= 1'b1;
              r_pslverr <= !r_in_range;
              r_prdata  <= (r_in_range && !r_write) ? w_rd_word : '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 2 and 3 wait states) on a shared
// bus with per-instance select, checked against a word-array reference model.
module tb_apb_mem_slave;

  localparam int NI = 3;

  logic            pclk = 1'b0;
  logic            prst;
  logic [NI-1:0]   psel;
  logic            penable;
  logic            pwrite;
  logic [7:0]      paddr;
  logic [31:0]     pwdata;
  logic [3:0]      pstrb;
  logic [NI-1:0]   pready;
  logic [NI-1:0]   pslverr;
  logic [31:0]     prdata [NI];

  int              n_cmp = 0;
  int              n_err = 0;
  logic [31:0]     mdl [NI][16];
  logic [31:0]     last_rd;
  logic            last_err;

  always #5 pclk = ~pclk;

  apb_mem_slave #(.ADDR_WIDTH(8), .WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
    .pclk(pclk), .prst(prst), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  apb_mem_slave #(.ADDR_WIDTH(8), .WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) u_w2 (
    .pclk(pclk), .prst(prst), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  apb_mem_slave #(.ADDR_WIDTH(8), .WIDTH(32), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
    .pclk(pclk), .prst(prst), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

  function automatic int wait_of(input int inst);
    case (inst)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] mdl_read(input int inst, input logic [7:0] addr);
    int idx;
    idx = int'(addr) / 4;
    return (idx < 16) ? mdl[inst][idx] : 32'h0;
  endfunction

  task automatic mdl_write(input int inst, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 16) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdl[inst][idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 16; w++) mdl[i][w] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_bus();
    psel = '0; penable = 1'b0;
  endtask

  // One complete APB transfer on instance inst, checked against the model.
  task automatic xfer(input int inst, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input string tag);
    int waits;
    bit done;
    psel = '0; psel[inst] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    tick();
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (pready[inst] === 1'b1) done = 1'b1;
      else begin
        waits++;
        tick();
      end
    end
    check($sformatf("%s/ready", tag), 32'(done), 32'd1);
    if (done) begin
      last_rd  = prdata[inst];
      last_err = pslverr[inst];
      check($sformatf("%s/waits", tag), 32'(waits), 32'(wait_of(inst)));
      check($sformatf("%s/slverr", tag), 32'(last_err), 32'((int'(addr) / 4) >= 16));
      if (!wr) check($sformatf("%s/rdata", tag), last_rd, mdl_read(inst, addr));
      tick();
      if (wr) mdl_write(inst, addr, wd, st);
      check($sformatf("%s/done", tag), 32'(pready[inst]), 32'd0);
    end
    idle_bus();
  endtask

  task automatic readback(input int inst, input string tag);
    for (int w = 0; w < 16; w++) xfer(inst, 1'b0, 8'(w * 4), 32'h0, 4'h0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prst = 1'b1;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    last_rd = '0; last_err = 1'b0;
    mdl_clear();

    #1 prst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d/pready", i), 32'(pready[i]), 32'd0);
      check($sformatf("rst%0d/pslverr", i), 32'(pslverr[i]), 32'd0);
      check($sformatf("rst%0d/prdata", i), prdata[i], 32'h0);
    end
    tick(); tick();
    prst = 1'b1;
    tick();

    // penable without a setup phase must be ignored
    psel[0] = 1'b1; penable = 1'b1; paddr = 8'h04;
    tick();
    check("noset/pready", 32'(pready[0]), 32'd0);
    tick();
    check("noset/pready2", 32'(pready[0]), 32'd0);
    idle_bus();
    tick();

    xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, "zw_wr");
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, "zw_rd");
    check("zw_rd/const", last_rd, 32'hDEADBEEF);

    xfer(2, 1'b0, 8'h00, 32'h0, 4'h0, "w3_rd");
    check("w3_rd/const", last_rd, 32'h0);

    xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF, "strb_wr1");
    xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'h5, "strb_wr2");
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, "strb_rd");
    check("strb_rd/const", last_rd, 32'h11BB33DD);

    xfer(0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, "oor_wr");
    xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, "oor_rd");
    check("oor_rd/err", 32'(last_err), 32'd1);
    readback(0, "oor_dump");

    // abort during WAIT on the 2-wait instance
    xfer(1, 1'b1, 8'h0C, 32'h01020304, 4'hF, "abw_pre");
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h0C; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    check("abw/wait", 32'(pready[1]), 32'd0);
    idle_bus();
    tick();
    check("abw/idle", 32'(pready[1]), 32'd0);
    xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, "abw_rd");
    check("abw_rd/const", last_rd, 32'h01020304);

    // abort while READY on the zero-wait instance
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h14; pwdata = 32'h77777777; pstrb = 4'hF;
    tick();
    check("abr/ready", 32'(pready[0]), 32'd1);
    idle_bus();
    tick();
    check("abr/idle", 32'(pready[0]), 32'd0);
    xfer(0, 1'b0, 8'h14, 32'h0, 4'h0, "abr_rd");

    // reset while a read is presenting data
    psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    tick();
    check("mrst/ready", 32'(pready[0]), 32'd1);
    check("mrst/rdata", prdata[0], 32'hDEADBEEF);
    prst = 1'b0;
    #1;
    check("mrst/pready", 32'(pready[0]), 32'd0);
    check("mrst/prdata", prdata[0], 32'h0);
    idle_bus();
    mdl_clear();
    tick();
    prst = 1'b1;
    tick();
    readback(0, "mrst_dump");
    xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, "mrst_w2");

    // back-to-back: read setup presented on the write's completing edge
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h10; pwdata = 32'h0000CAFE; pstrb = 4'hF;
    tick();
    check("b2b/wr_ready", 32'(pready[0]), 32'd1);
    pwrite = 1'b0;
    tick();
    mdl_write(0, 8'h10, 32'h0000CAFE, 4'hF);
    check("b2b/rd_ready", 32'(pready[0]), 32'd1);
    check("b2b/rd_data", prdata[0], 32'h0000CAFE);
    check("b2b/rd_err", 32'(pslverr[0]), 32'd0);
    penable = 1'b1;
    tick();
    check("b2b/done", 32'(pready[0]), 32'd0);
    idle_bus();
    tick();

    for (int n = 0; n < 80; n++) begin
      int          inst;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  st;
      inst = int'($urandom_range(0, NI - 1));
      wr   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 8'h4F));
      data = $urandom;
      st   = 4'($urandom_range(0, 15));
      xfer(inst, wr, addr, data, st, $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < NI; i++) readback(i, $sformatf("final%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
